// File: rtl/sa_cache_ctrl.sv
// ============================================================================
// Module   : sa_cache_ctrl
// Purpose  : Single-requester miss/refill sequencer around sa_cache; handles
//            lookup, dirty write-back, refill, install and replay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    // sa_cache side
    output logic [17:0]       c_tag,
    output logic [7:0]        c_index,
    output logic [5:0]        c_offset,
    output logic [DATA_W-1:0] c_dataW,
    output logic              c_memRW,
    input  logic [DATA_W-1:0] c_data,
    input  logic              c_miss,
    input  logic              c_evict,
    input  logic [ADDR_W-1:0] c_evict_addr,
    input  logic [DATA_W-1:0] c_evict_data,
    output logic [DATA_W-1:0] c_mem_line,
    output logic              c_mem_response,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_LOOKUP  = 3'd1;
    localparam logic [2:0] C_WB      = 3'd2;
    localparam logic [2:0] C_FILL    = 3'd3;
    localparam logic [2:0] C_INSTALL = 3'd4;
    localparam logic [2:0] C_RESP    = 3'd5;

    localparam logic [7:0] C_WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_evict_addr;
    logic [DATA_W-1:0] r_evict_data;
    logic [DATA_W-1:0] r_refill;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_replay;
    logic [7:0]        r_wait_cnt;

    logic              w_mem_phase;
    logic              w_ack_ok;
    logic              w_wait_expired;

    // Memory traffic only exists in WB/FILL, so an ack elsewhere is dropped.
    assign w_mem_phase    = (r_state == C_WB) || (r_state == C_FILL);
    assign w_ack_ok       = mem_ack && w_mem_phase;
    assign w_wait_expired = (r_wait_cnt == C_WAIT_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (cpu_req) begin
                    w_next_state = C_LOOKUP;
                end
            end
            C_LOOKUP: begin
                // A miss after a replay means the install did not take: report it.
                if (!c_miss || r_replay) begin
                    w_next_state = C_RESP;
                end else if (c_evict) begin
                    w_next_state = C_WB;
                end else begin
                    w_next_state = C_FILL;
                end
            end
            C_WB: begin
                if (w_ack_ok) begin
                    w_next_state = C_FILL;
                end else if (w_wait_expired) begin
                    w_next_state = C_RESP;
                end
            end
            C_FILL: begin
                if (w_ack_ok) begin
                    w_next_state = C_INSTALL;
                end else if (w_wait_expired) begin
                    w_next_state = C_RESP;
                end
            end
            C_INSTALL: w_next_state = C_LOOKUP;
            C_RESP:    w_next_state = C_IDLE;
            default:   w_next_state = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_evict_addr <= '0;
            r_evict_data <= '0;
            r_refill     <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_replay     <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                    end
                end
                C_LOOKUP: begin
                    if (!c_miss) begin
                        r_rdata <= r_we ? '0 : c_data;
                        r_err   <= 1'b0;
                    end else if (r_replay) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= '0;
                        if (c_evict) begin
                            r_evict_addr <= c_evict_addr;
                            r_evict_data <= c_evict_data;
                        end
                    end
                end
                C_WB, C_FILL: begin
                    if (w_ack_ok) begin
                        r_wait_cnt <= '0;
                        if (r_state == C_FILL) begin
                            r_refill <= mem_rdata;
                        end
                    end else if (w_wait_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                C_INSTALL: begin
                    r_replay <= 1'b1;
                end
                C_RESP: begin
                    r_replay <= 1'b0;
                    r_rdata  <= '0;
                    r_err    <= 1'b0;
                end
                default: begin
                    r_replay <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign c_tag    = r_addr[ADDR_W-1:14];
    assign c_index  = r_addr[13:6];
    assign c_offset = r_addr[5:0];
    assign c_dataW  = r_wdata;

    always_comb begin
        cpu_ready      = 1'b0;
        cpu_rvalid     = 1'b0;
        cpu_rdata      = '0;
        cpu_err        = 1'b0;
        c_memRW        = 1'b0;
        c_mem_line     = r_refill;
        c_mem_response = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (r_state)
            C_IDLE: begin
                // Held low while rst is asserted so ready only appears once reset lifts.
                cpu_ready = !rst;
            end
            C_LOOKUP: begin
                c_memRW = r_we;
            end
            C_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_evict_addr;
                mem_wdata = r_evict_data;
            end
            C_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            end
            C_INSTALL: begin
                c_mem_response = 1'b1;
            end
            C_RESP: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = r_rdata;
                cpu_err    = r_err;
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sa_cache_ctrl.sv
// ============================================================================
// Module   : tb_sa_cache_ctrl
// Purpose  : Directed self-checking bench for sa_cache_ctrl (hit table plus
//            miss, write-back, timeout, replay-miss and reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [17:0] c_tag;
    logic [7:0]  c_index;
    logic [5:0]  c_offset;
    logic [31:0] c_dataW;
    logic        c_memRW;
    logic [31:0] c_data;
    logic        c_miss;
    logic        c_evict;
    logic [31:0] c_evict_addr;
    logic [31:0] c_evict_data;
    logic [31:0] c_mem_line;
    logic        c_mem_response;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    sa_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_dataW(c_dataW),
        .c_memRW(c_memRW), .c_data(c_data), .c_miss(c_miss), .c_evict(c_evict),
        .c_evict_addr(c_evict_addr), .c_evict_data(c_evict_data),
        .c_mem_line(c_mem_line), .c_mem_response(c_mem_response),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cdata;
        logic [17:0] tag;
        logic [7:0]  index;
        logic [5:0]  offset;
        logic [31:0] rdata;
    } hit_vec_t;

    hit_vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Present one request at a post-edge point; the following edge accepts it.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 32'h0000_0044, 32'h0,         32'hDEAD_BEEF, 18'h0,     8'h01, 6'h04, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h5555_5555, 18'h3FFFF, 8'hFF, 6'h3F, 32'h0};
        vecs[2] = '{1'b0, 32'h8000_4001, 32'h0,         32'hCAFE_F00D, 18'h20001, 8'h00, 6'h01, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 32'h0000_3FC0, 32'h0,         32'h0123_4567, 18'h0,     8'hFF, 6'h00, 32'h0123_4567};
        vecs[4] = '{1'b1, 32'h0001_4008, 32'h1357_9BDF, 32'h89AB_CDEF, 18'h5,     8'h00, 6'h08, 32'h0};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        c_data = '0; c_miss = 1'b0; c_evict = 1'b0; c_evict_addr = '0; c_evict_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // ---- power-up reset ----
        tick();
        tick();
        check_bit("reset ready", cpu_ready, 1'b0);
        check_bit("reset rvalid", cpu_rvalid, 1'b0);
        check_bit("reset mem_req", mem_req, 1'b0);
        check_bit("reset mem_response", c_mem_response, 1'b0);
        check_word("reset tag", 32'(c_tag), 32'h0);
        rst = 1'b0;
        #1;
        check_bit("ready after reset", cpu_ready, 1'b1);

        // ---- hit table ----
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            c_miss = 1'b0;
            c_evict = 1'b0;
            c_data = vecs[i].cdata;
            check_bit($sformatf("hit%0d ready", i), cpu_ready, 1'b1);
            tick();
            cpu_req = 1'b0;
            check_word($sformatf("hit%0d tag", i), 32'(c_tag), 32'(vecs[i].tag));
            check_word($sformatf("hit%0d index", i), 32'(c_index), 32'(vecs[i].index));
            check_word($sformatf("hit%0d offset", i), 32'(c_offset), 32'(vecs[i].offset));
            check_bit($sformatf("hit%0d memRW", i), c_memRW, vecs[i].we);
            check_word($sformatf("hit%0d dataW", i), c_dataW, vecs[i].wdata);
            check_bit($sformatf("hit%0d early rvalid", i), cpu_rvalid, 1'b0);
            check_bit($sformatf("hit%0d ready busy", i), cpu_ready, 1'b0);
            tick();
            check_bit($sformatf("hit%0d rvalid", i), cpu_rvalid, 1'b1);
            check_word($sformatf("hit%0d rdata", i), cpu_rdata, vecs[i].rdata);
            check_bit($sformatf("hit%0d err", i), cpu_err, 1'b0);
            check_bit($sformatf("hit%0d mem_req", i), mem_req, 1'b0);
            tick();
            check_bit($sformatf("hit%0d ready back", i), cpu_ready, 1'b1);
            check_bit($sformatf("hit%0d rvalid drop", i), cpu_rvalid, 1'b0);
        end

        // ---- clean miss, ack on 3rd req cycle, cpu_req held high throughout ----
        issue(1'b0, 32'h0001_4008, 32'h0);
        c_miss = 1'b1; c_evict = 1'b0;
        tick();
        check_bit("clean lookup ready", cpu_ready, 1'b0);
        tick();
        check_bit("clean fill req", mem_req, 1'b1);
        check_bit("clean fill we", mem_we, 1'b0);
        check_word("clean fill addr", mem_addr, 32'h0001_4008);
        check_bit("clean fill ready", cpu_ready, 1'b0);
        tick();
        check_bit("clean fill req c2", mem_req, 1'b1);
        check_word("clean fill addr c2", mem_addr, 32'h0001_4008);
        tick();
        check_bit("clean fill req c3", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check_bit("clean install resp", c_mem_response, 1'b1);
        check_word("clean install line", c_mem_line, 32'h1234_5678);
        check_bit("clean install req", mem_req, 1'b0);
        c_miss = 1'b0; c_data = 32'h1234_5678;
        tick();
        check_bit("clean replay resp drop", c_mem_response, 1'b0);
        check_bit("clean replay rvalid", cpu_rvalid, 1'b0);
        check_bit("clean replay ready", cpu_ready, 1'b0);
        tick();
        check_bit("clean rvalid", cpu_rvalid, 1'b1);
        check_word("clean rdata", cpu_rdata, 32'h1234_5678);
        check_bit("clean err", cpu_err, 1'b0);
        tick();
        check_bit("clean ready back", cpu_ready, 1'b1);
        check_bit("clean no extra rvalid", cpu_rvalid, 1'b0);
        cpu_req = 1'b0;

        // ---- stray ack while idle is ignored ----
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_bit("stray ack req", mem_req, 1'b0);
        check_bit("stray ack ready", cpu_ready, 1'b1);

        // ---- dirty miss store, immediate acks: rvalid 6 cycles after request ----
        issue(1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        c_miss = 1'b1; c_evict = 1'b1;
        c_evict_addr = 32'h0004_0080; c_evict_data = 32'h1111_1111;
        tick();
        cpu_req = 1'b0;
        check_bit("dirty lookup memRW", c_memRW, 1'b1);
        tick();
        c_evict = 1'b0; c_evict_addr = '0; c_evict_data = '0;
        check_bit("dirty wb req", mem_req, 1'b1);
        check_bit("dirty wb we", mem_we, 1'b1);
        check_word("dirty wb addr", mem_addr, 32'h0004_0080);
        check_word("dirty wb wdata", mem_wdata, 32'h1111_1111);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        check_bit("dirty fill req", mem_req, 1'b1);
        check_bit("dirty fill we", mem_we, 1'b0);
        check_word("dirty fill addr", mem_addr, 32'h0000_0080);
        tick();
        mem_ack = 1'b0;
        check_bit("dirty install resp", c_mem_response, 1'b1);
        check_word("dirty install line", c_mem_line, 32'h7777_7777);
        c_miss = 1'b0; c_data = 32'h7777_7777;
        tick();
        check_bit("dirty replay memRW", c_memRW, 1'b1);
        check_word("dirty replay dataW", c_dataW, 32'hA5A5_A5A5);
        tick();
        check_bit("dirty rvalid", cpu_rvalid, 1'b1);
        check_bit("dirty err", cpu_err, 1'b0);
        check_word("dirty rdata", cpu_rdata, 32'h0);
        tick();

        // ---- timeout: no ack at all ----
        issue(1'b0, 32'h0000_1000, 32'h0);
        c_miss = 1'b1; c_evict = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        n = 0;
        while (mem_req && n < 100) begin
            n++;
            tick();
        end
        check_word("timeout req cycles", 32'(n), 32'd64);
        check_bit("timeout rvalid", cpu_rvalid, 1'b1);
        check_bit("timeout err", cpu_err, 1'b1);
        check_word("timeout rdata", cpu_rdata, 32'h0);
        tick();
        check_bit("timeout ready", cpu_ready, 1'b1);

        // ---- ack on the limit cycle wins ----
        issue(1'b0, 32'h0000_2000, 32'h0);
        c_miss = 1'b1; c_evict = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        for (int k = 0; k < 63; k++) tick();
        check_bit("limit req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        tick();
        mem_ack = 1'b0;
        check_bit("limit install", c_mem_response, 1'b1);
        check_bit("limit no rvalid", cpu_rvalid, 1'b0);
        c_miss = 1'b0; c_data = 32'h0F0F_0F0F;
        tick();
        tick();
        check_bit("limit rvalid", cpu_rvalid, 1'b1);
        check_bit("limit err", cpu_err, 1'b0);
        check_word("limit rdata", cpu_rdata, 32'h0F0F_0F0F);
        tick();

        // ---- replay still misses: error, no second fill ----
        issue(1'b0, 32'h0000_3000, 32'h0);
        c_miss = 1'b1; c_evict = 1'b0;
        tick();
        cpu_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        check_bit("rmiss fill req", mem_req, 1'b1);
        tick();
        mem_ack = 1'b0;
        check_bit("rmiss install", c_mem_response, 1'b1);
        c_evict = 1'b1; c_evict_addr = 32'h0009_3000;
        tick();
        check_bit("rmiss replay req", mem_req, 1'b0);
        tick();
        check_bit("rmiss rvalid", cpu_rvalid, 1'b1);
        check_bit("rmiss err", cpu_err, 1'b1);
        check_bit("rmiss no refill", mem_req, 1'b0);
        tick();
        check_bit("rmiss ready", cpu_ready, 1'b1);
        c_evict = 1'b0;

        // ---- reset held two cycles in the middle of a fill ----
        issue(1'b0, 32'h0000_4000, 32'h0);
        c_miss = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        check_bit("rstmid fill req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        check_bit("rstmid req", mem_req, 1'b0);
        check_bit("rstmid rvalid", cpu_rvalid, 1'b0);
        check_bit("rstmid ready", cpu_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_bit("rstmid ready after", cpu_ready, 1'b1);
        check_bit("rstmid req after", mem_req, 1'b0);
        tick();
        check_bit("rstmid no rvalid", cpu_rvalid, 1'b0);
        check_bit("rstmid idle", cpu_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
